// File: rtl/cpu_pkg.sv
// Shared encodings for the cpu_core datapath: ALU opcodes, branch
// conditions, flag bit positions and register write-source selects.
package cpu_pkg;

  // ALU operation class, decoded from OP[2:0]; OP[3] picks the variant
  localparam logic [2:0] ALU_ADDSUB = 3'b000;
  localparam logic [2:0] ALU_XOR    = 3'b001;
  localparam logic [2:0] ALU_AND    = 3'b010;
  localparam logic [2:0] ALU_ORNOR  = 3'b011;
  localparam logic [2:0] ALU_SHL    = 3'b100;
  localparam logic [2:0] ALU_SHR    = 3'b101;
  localparam logic [2:0] ALU_ROL    = 3'b110;
  localparam logic [2:0] ALU_ROR    = 3'b111;

  // Full opcodes where OP[3] changes the function
  localparam logic [3:0] OP_SUB = 4'b1000;
  localparam logic [3:0] OP_NOR = 4'b1011;

  // Branch condition codes (OP field when JMP_INST=1)
  localparam logic [3:0] BR_ALWAYS = 4'b0111;
  localparam logic [3:0] BR_JE     = 4'b1011;
  localparam logic [3:0] BR_JNE    = 4'b0011;
  localparam logic [3:0] BR_JC     = 4'b0101;
  localparam logic [3:0] BR_JNC    = 4'b1101;
  localparam logic [3:0] BR_JN     = 4'b0110;
  localparam logic [3:0] BR_JNN    = 4'b1110;

  // Flag bit positions inside FLAGS
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_V = 3;

  // Register write-source select {MS1,MS0}
  localparam logic [1:0] MS_ALU      = 2'b00;
  localparam logic [1:0] MS_REGA     = 2'b01;
  localparam logic [1:0] MS_IMM      = 2'b10;
  localparam logic [1:0] MS_IMM_RSVD = 2'b11;

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: add/sub, logic ops, shifts and rotates with Z/C/N/V.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   op,
  output logic [W-1:0] y,
  output logic         z,
  output logic         c,
  output logic         n,
  output logic         v
);

  localparam int SH_W = $clog2(W);

  logic           subtract;
  logic [W-1:0]   b_eff;
  logic [W:0]     sum;
  logic [SH_W-1:0] sh;
  logic [2*W-1:0] dbl;
  logic [2*W-1:0] rol_w;
  logic [2*W-1:0] ror_w;

  // Subtraction is A + ~B + 1, so one adder serves both and C is the raw carry
  assign subtract = (op == OP_SUB);
  assign b_eff    = subtract ? ~b : b;
  assign sum      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, subtract};

  // Rotates take the matching half of A concatenated with itself
  assign sh    = b[SH_W-1:0];
  assign dbl   = {a, a};
  assign rol_w = dbl << sh;
  assign ror_w = dbl >> sh;

  // Result and arithmetic flags; C and V are only meaningful for add/sub
  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    case (op[2:0])
      ALU_ADDSUB: begin
        y = sum[W-1:0];
        c = sum[W];
        v = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
      end
      ALU_XOR:   y = a ^ b;
      ALU_AND:   y = a & b;
      ALU_ORNOR: y = (op == OP_NOR) ? ~(a | b) : (a | b);
      ALU_SHL:   y = a << sh;
      ALU_SHR:   y = a >> sh;
      ALU_ROL:   y = rol_w[2*W-1:W];
      ALU_ROR:   y = ror_w[W-1:0];
      default:   y = '0;
    endcase
  end

  assign z = (y == '0);
  assign n = y[W-1];

endmodule

// File: rtl/cpu_core.sv
// Single-cycle 8-bit CPU datapath: register bank, ALU, flags and IP/branch.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  output logic [W-1:0] Addr,
  output logic [W-1:0] FLAGS,
  output logic [W-1:0] R0,
  output logic [W-1:0] R1,
  output logic [W-1:0] R2,
  output logic [W-1:0] R3,
  output logic [W-1:0] R4,
  output logic [W-1:0] R5,
  output logic [W-1:0] R6,
  output logic [W-1:0] R7,
  input  logic         MEM_INST,
  input  logic         ALU_INST,
  input  logic         JMP_INST,
  input  logic         MS1,
  input  logic         MS0,
  input  logic         IRS,
  input  logic         TS2,
  input  logic         TS1,
  input  logic         TS0,
  input  logic         AR2,
  input  logic         AR1,
  input  logic         AR0,
  input  logic         BS2,
  input  logic         BS1,
  input  logic         BS0,
  input  logic [3:0]   OP,
  input  logic [W-1:0] IMM
);

  logic [2:0]   ts_idx;
  logic [2:0]   ar_idx;
  logic [2:0]   bs_idx;
  logic [1:0]   ms_sel;
  logic [W-1:0] regs [8];
  logic [W-1:0] flags_q;
  logic [W-1:0] ip_q;
  logic [W-1:0] a_op;
  logic [W-1:0] b_op;
  logic [W-1:0] alu_y;
  logic         alu_z;
  logic         alu_c;
  logic         alu_n;
  logic         alu_v;
  logic [W-1:0] wr_data;
  logic [W-1:0] flags_next;
  logic         branch_taken;

  // Branch condition against the flags held before this edge
  function automatic logic cond_met(input logic [3:0] code, input logic [W-1:0] fl);
    logic met;
    case (code)
      BR_ALWAYS: met = 1'b1;
      BR_JE:     met = fl[FLAG_Z];
      BR_JNE:    met = ~fl[FLAG_Z];
      BR_JC:     met = fl[FLAG_C];
      BR_JNC:    met = ~fl[FLAG_C];
      BR_JN:     met = fl[FLAG_N];
      BR_JNN:    met = ~fl[FLAG_N];
      default:   met = 1'b0;
    endcase
    return met;
  endfunction

  assign ts_idx = {TS2, TS1, TS0};
  assign ar_idx = {AR2, AR1, AR0};
  assign bs_idx = {BS2, BS1, BS0};
  assign ms_sel = {MS1, MS0};

  // Operands are read from pre-edge state, so TS==AR/BS sees the old value
  assign a_op = regs[ar_idx];
  assign b_op = IRS ? IMM : regs[bs_idx];

  cpu_alu #(.W(W)) u_alu (
    .a  (a_op),
    .b  (b_op),
    .op (OP),
    .y  (alu_y),
    .z  (alu_z),
    .c  (alu_c),
    .n  (alu_n),
    .v  (alu_v)
  );

  // Register write-source mux
  always_comb begin
    wr_data = IMM;
    case (ms_sel)
      MS_ALU:      wr_data = alu_y;
      MS_REGA:     wr_data = a_op;
      MS_IMM:      wr_data = IMM;
      MS_IMM_RSVD: wr_data = IMM;
      default:     wr_data = IMM;
    endcase
  end

  // Pack ALU flags into their architectural bit positions
  always_comb begin
    flags_next         = '0;
    flags_next[FLAG_Z] = alu_z;
    flags_next[FLAG_C] = alu_c;
    flags_next[FLAG_N] = alu_n;
    flags_next[FLAG_V] = alu_v;
  end

  assign branch_taken = JMP_INST && cond_met(OP, flags_q);

  // Register bank write on MEM_INST
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
    end else if (MEM_INST) begin
      regs[ts_idx] <= wr_data;
    end
  end

  // Flags register update on ALU_INST
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) flags_q <= '0;
    else if (ALU_INST) flags_q <= flags_next;
  end

  // Instruction pointer: taken branch lands one past the target, else increment
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ip_q <= '0;
    else if (branch_taken) ip_q <= IMM + 1'b1;
    else ip_q <= ip_q + 1'b1;
  end

  assign Addr  = ip_q;
  assign FLAGS = flags_q;
  assign R0    = regs[0];
  assign R1    = regs[1];
  assign R2    = regs[2];
  assign R3    = regs[3];
  assign R4    = regs[4];
  assign R5    = regs[5];
  assign R6    = regs[6];
  assign R7    = regs[7];

endmodule

// File: tb/tb_cpu_core.sv
// Directed self-checking bench for cpu_core.
module tb_cpu_core;

  logic       CLK;
  logic       RST;
  logic [7:0] Addr;
  logic [7:0] FLAGS;
  logic [7:0] R0, R1, R2, R3, R4, R5, R6, R7;
  logic       MEM_INST, ALU_INST, JMP_INST;
  logic       MS1, MS0, IRS;
  logic       TS2, TS1, TS0, AR2, AR1, AR0, BS2, BS1, BS0;
  logic [3:0] OP;
  logic [7:0] IMM;

  logic [7:0] robs [8];
  logic [7:0] exp_ip;
  int         total;
  int         passed;

  cpu_core #(.W(8)) dut (
    .CLK(CLK), .RST(RST), .Addr(Addr), .FLAGS(FLAGS),
    .R0(R0), .R1(R1), .R2(R2), .R3(R3), .R4(R4), .R5(R5), .R6(R6), .R7(R7),
    .MEM_INST(MEM_INST), .ALU_INST(ALU_INST), .JMP_INST(JMP_INST),
    .MS1(MS1), .MS0(MS0), .IRS(IRS),
    .TS2(TS2), .TS1(TS1), .TS0(TS0),
    .AR2(AR2), .AR1(AR1), .AR0(AR0),
    .BS2(BS2), .BS1(BS1), .BS0(BS0),
    .OP(OP), .IMM(IMM)
  );

  assign robs[0] = R0;
  assign robs[1] = R1;
  assign robs[2] = R2;
  assign robs[3] = R3;
  assign robs[4] = R4;
  assign robs[5] = R5;
  assign robs[6] = R6;
  assign robs[7] = R7;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic drive(input logic mem, input logic alu, input logic jmp,
                       input logic [1:0] ms, input logic irs, input logic [2:0] ts,
                       input logic [2:0] ar, input logic [2:0] bs,
                       input logic [3:0] op, input logic [7:0] imm);
    MEM_INST = mem; ALU_INST = alu; JMP_INST = jmp;
    {MS1, MS0} = ms; IRS = irs;
    {TS2, TS1, TS0} = ts; {AR2, AR1, AR0} = ar; {BS2, BS1, BS0} = bs;
    OP = op; IMM = imm;
  endtask

  // Apply one instruction for one edge; sample 1 time unit after the edge
  task automatic issue(input logic mem, input logic alu, input logic jmp,
                       input logic [1:0] ms, input logic irs, input logic [2:0] ts,
                       input logic [2:0] ar, input logic [2:0] bs,
                       input logic [3:0] op, input logic [7:0] imm);
    drive(mem, alu, jmp, ms, irs, ts, ar, bs, op, imm);
    @(posedge CLK);
    #1;
    exp_ip = exp_ip + 8'd1;
  endtask

  task automatic test_reset();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'd0, 8'd0);
    RST = 1'b0;
    #2 RST = 1'b1;
    #2;
    total++; if (Addr !== 8'd0) $display("FAIL reset_addr: got %0d expected 0", Addr); else passed++;
    total++; if (FLAGS !== 8'd0) $display("FAIL reset_flags: got %0h expected 0", FLAGS); else passed++;
    for (int i = 0; i < 8; i++) begin
      total++;
      if (robs[i] !== 8'd0) $display("FAIL reset_R%0d: got %0d expected 0", i, robs[i]); else passed++;
    end
    repeat (2) @(posedge CLK);
    #1;
    total++; if (Addr !== 8'd0) $display("FAIL reset_hold_addr: got %0d expected 0", Addr); else passed++;
    #1 RST = 1'b0;
    exp_ip = 8'd0;
    for (int i = 1; i <= 3; i++) begin
      issue(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'd0, 8'd0);
      total++;
      if (Addr !== 8'(i)) $display("FAIL nop_addr%0d: got %0d expected %0d", i, Addr, i); else passed++;
    end
    total++; if (FLAGS !== 8'd0) $display("FAIL nop_flags: got %0h expected 0", FLAGS); else passed++;
    total++;
    if ({R0, R1, R2, R3, R4, R5, R6, R7} !== 64'd0)
      $display("FAIL nop_regs: got %0h expected 0", {R0, R1, R2, R3, R4, R5, R6, R7});
    else passed++;
    issue(0, 0, 1, 2'b00, 0, 0, 0, 0, 4'b0111, 8'd10);
    exp_ip = 8'd11;
    total++; if (Addr !== 8'd11) $display("FAIL jmp10: got %0d expected 11", Addr); else passed++;
    issue(0, 0, 1, 2'b00, 0, 0, 0, 0, 4'b0111, 8'd255);
    exp_ip = 8'd0;
    total++; if (Addr !== 8'd0) $display("FAIL jmp255_wrap: got %0d expected 0", Addr); else passed++;
  endtask

  task automatic test_accumulate();
    issue(1, 0, 0, 2'b10, 0, 3'd3, 0, 0, 4'd0, 8'd0);
    total++; if (R3 !== 8'd0) $display("FAIL mov_r3: got %0d expected 0", R3); else passed++;
    for (int i = 1; i <= 8; i++) begin
      issue(1, 1, 0, 2'b00, 1, 3'd3, 3'd3, 0, 4'b0000, 8'd1);
      total++;
      if (R3 !== 8'(i)) $display("FAIL acc_step%0d: got %0d expected %0d", i, R3, i); else passed++;
    end
    total++; if (FLAGS !== 8'h00) $display("FAIL acc_flags: got %0h expected 0", FLAGS); else passed++;
    total++; if (Addr !== exp_ip) $display("FAIL acc_addr: got %0d expected %0d", Addr, exp_ip); else passed++;
  endtask

  task automatic test_reg_ops();
    issue(1, 0, 0, 2'b10, 0, 3'd0, 0, 0, 4'd0, 8'd5);
    issue(1, 0, 0, 2'b10, 0, 3'd1, 0, 0, 4'd0, 8'd7);
    issue(1, 1, 0, 2'b00, 0, 3'd0, 3'd0, 3'd1, 4'b0000, 8'd0);
    total++; if (R0 !== 8'd12) $display("FAIL add_rr: got %0d expected 12", R0); else passed++;
    issue(1, 1, 0, 2'b00, 1, 3'd0, 3'd0, 0, 4'b0000, 8'd9);
    total++; if (R0 !== 8'd21) $display("FAIL add_imm: got %0d expected 21", R0); else passed++;
    issue(1, 0, 0, 2'b01, 0, 3'd7, 3'd1, 0, 4'd0, 8'd0);
    total++; if (R7 !== 8'd7) $display("FAIL mov_r7_r1: got %0d expected 7", R7); else passed++;
  endtask

  task automatic test_cmp_branch();
    issue(0, 1, 0, 2'b00, 1, 0, 3'd7, 0, 4'b1000, 8'd7);
    total++; if (FLAGS !== 8'h03) $display("FAIL cmp_eq_flags: got %0h expected 03", FLAGS); else passed++;
    total++; if (R7 !== 8'd7) $display("FAIL cmp_r7_kept: got %0d expected 7", R7); else passed++;
    issue(0, 0, 1, 2'b00, 0, 0, 0, 0, 4'b1011, 8'd63);
    exp_ip = 8'd64;
    total++; if (Addr !== 8'd64) $display("FAIL je_taken: got %0d expected 64", Addr); else passed++;
    issue(0, 1, 0, 2'b00, 1, 0, 3'd7, 0, 4'b1000, 8'd8);
    total++; if (FLAGS !== 8'h04) $display("FAIL cmp_lt_flags: got %0h expected 04", FLAGS); else passed++;
    issue(0, 0, 1, 2'b00, 0, 0, 0, 0, 4'b1011, 8'd63);
    total++; if (Addr !== 8'd66) $display("FAIL je_not_taken: got %0d expected 66", Addr); else passed++;
    issue(0, 0, 1, 2'b00, 0, 0, 0, 0, 4'b0011, 8'd100);
    exp_ip = 8'd101;
    total++; if (Addr !== 8'd101) $display("FAIL jne_taken: got %0d expected 101", Addr); else passed++;
  endtask

  task automatic test_shift_rotate();
    issue(1, 1, 0, 2'b00, 1, 3'd5, 3'd0, 0, 4'b0100, 8'd3);
    total++; if (R5 !== 8'd168) $display("FAIL shl3: got %0d expected 168", R5); else passed++;
    total++; if (FLAGS !== 8'h04) $display("FAIL shl_flags: got %0h expected 04", FLAGS); else passed++;
    issue(1, 1, 0, 2'b00, 1, 3'd5, 3'd0, 0, 4'b0101, 8'd2);
    total++; if (R5 !== 8'd5) $display("FAIL shr2: got %0d expected 5", R5); else passed++;
    issue(1, 0, 0, 2'b10, 0, 3'd6, 0, 0, 4'd0, 8'h81);
    issue(1, 1, 0, 2'b00, 1, 3'd6, 3'd6, 0, 4'b0111, 8'd1);
    total++; if (R6 !== 8'hC0) $display("FAIL ror1: got %0h expected c0", R6); else passed++;
    issue(1, 0, 0, 2'b00, 1, 3'd4, 3'd6, 0, 4'b0110, 8'd1);
    total++; if (R4 !== 8'h81) $display("FAIL rol1: got %0h expected 81", R4); else passed++;
    issue(1, 0, 0, 2'b10, 0, 3'd1, 0, 0, 4'd0, 8'hF0);
    issue(1, 1, 0, 2'b00, 1, 3'd2, 3'd1, 0, 4'b1011, 8'h0F);
    total++; if (R2 !== 8'h00) $display("FAIL nor: got %0h expected 00", R2); else passed++;
    total++; if (FLAGS !== 8'h01) $display("FAIL nor_flags: got %0h expected 01", FLAGS); else passed++;
  endtask

  task automatic test_carry_overflow();
    issue(1, 0, 0, 2'b10, 0, 3'd4, 0, 0, 4'd0, 8'hFF);
    issue(1, 1, 0, 2'b00, 1, 3'd4, 3'd4, 0, 4'b0000, 8'd1);
    total++; if (R4 !== 8'h00) $display("FAIL add_wrap: got %0h expected 00", R4); else passed++;
    total++; if (FLAGS !== 8'h03) $display("FAIL add_carry_flags: got %0h expected 03", FLAGS); else passed++;
    issue(1, 0, 0, 2'b10, 0, 3'd4, 0, 0, 4'd0, 8'h7F);
    issue(1, 1, 0, 2'b00, 1, 3'd4, 3'd4, 0, 4'b0000, 8'd1);
    total++; if (R4 !== 8'h80) $display("FAIL add_ovf: got %0h expected 80", R4); else passed++;
    total++; if (FLAGS !== 8'h0C) $display("FAIL add_ovf_flags: got %0h expected 0c", FLAGS); else passed++;
    issue(1, 1, 0, 2'b00, 1, 3'd4, 3'd4, 0, 4'b1000, 8'd1);
    total++; if (R4 !== 8'h7F) $display("FAIL sub_ovf: got %0h expected 7f", R4); else passed++;
    total++; if (FLAGS !== 8'h0A) $display("FAIL sub_ovf_flags: got %0h expected 0a", FLAGS); else passed++;
  endtask

  task automatic test_combined();
    // MS=10 writes IMM; ALU sees ROR R0(21) by R0[2:0]=5 -> 0xA8; jump always taken
    issue(1, 1, 1, 2'b10, 0, 3'd2, 3'd0, 3'd0, 4'b0111, 8'd200);
    exp_ip = 8'd201;
    total++; if (R2 !== 8'd200) $display("FAIL comb_reg: got %0d expected 200", R2); else passed++;
    total++; if (Addr !== 8'd201) $display("FAIL comb_addr: got %0d expected 201", Addr); else passed++;
    total++; if (FLAGS !== 8'h04) $display("FAIL comb_flags: got %0h expected 04", FLAGS); else passed++;
  endtask

  task automatic test_async_reset();
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'd0, 8'd0);
    #2 RST = 1'b1;
    #1;
    total++; if (Addr !== 8'd0) $display("FAIL async_addr: got %0d expected 0", Addr); else passed++;
    total++; if (FLAGS !== 8'd0) $display("FAIL async_flags: got %0h expected 0", FLAGS); else passed++;
    total++;
    if ({R0, R1, R2, R3, R4, R5, R6, R7} !== 64'd0)
      $display("FAIL async_regs: got %0h expected 0", {R0, R1, R2, R3, R4, R5, R6, R7});
    else passed++;
    #2 RST = 1'b0;
    exp_ip = 8'd0;
    issue(0, 0, 0, 2'b00, 0, 0, 0, 0, 4'd0, 8'd0);
    total++; if (Addr !== 8'd1) $display("FAIL resume_addr: got %0d expected 1", Addr); else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    exp_ip = 8'd0;
    RST    = 1'b0;
    test_reset();
    test_accumulate();
    test_reg_ops();
    test_cmp_branch();
    test_shift_rotate();
    test_carry_overflow();
    test_combined();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
